// File: rtl/spi_wr_buffer_pkg.sv
// Shared constants and the stored entry type for the SPI write buffer.
package wr_buf_pkg;

  // Default widths, matching the SPI frame receiver's write outputs.
  localparam int DEF_ADDR_W = 24;
  localparam int DEF_DATA_W = 32;

  // Width of the saturating dropped-write counter.
  localparam int DROP_CNT_W = 8;

  // One buffered write: address in the upper bits, data in the lower bits.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wr_entry_t;

  // Width needed to hold a fill level from 0 up to and including depth.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_wr_buffer_if.sv
// Write-strobe input, head-of-queue handshake and status bundle of the buffer.
interface spi_wr_buffer_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = wr_buf_pkg::DEF_ADDR_W,
  parameter int DATA_W = wr_buf_pkg::DEF_DATA_W
);
  localparam int LVL_W = wr_buf_pkg::level_width(DEPTH);

  // Producer side (SPI receiver)
  logic                            wr_en_in;
  logic [ADDR_W-1:0]               wr_address_in;
  logic [DATA_W-1:0]               wr_data_in;
  // Consumer side (memory / register file)
  logic                            rd_valid_out;
  logic                            rd_ready_in;
  logic [ADDR_W-1:0]               rd_address_out;
  logic [DATA_W-1:0]               rd_data_out;
  // Status and overflow control
  logic [LVL_W-1:0]                level_out;
  logic                            full_out;
  logic                            empty_out;
  logic                            overflow_out;
  logic                            clear_ovf_in;
  logic [wr_buf_pkg::DROP_CNT_W-1:0] drop_count_out;

  // The buffer itself
  modport slave (
    input  wr_en_in, wr_address_in, wr_data_in, rd_ready_in, clear_ovf_in,
    output rd_valid_out, rd_address_out, rd_data_out, level_out,
           full_out, empty_out, overflow_out, drop_count_out
  );

  // Whatever drives the buffer and consumes its head
  modport master (
    output wr_en_in, wr_address_in, wr_data_in, rd_ready_in, clear_ovf_in,
    input  rd_valid_out, rd_address_out, rd_data_out, level_out,
           full_out, empty_out, overflow_out, drop_count_out
  );

endinterface

// File: rtl/spi_wr_buffer_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
// The asynchronous read is what gives the buffer its fall-through head.
module wr_buf_mem
  import wr_buf_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = wr_entry_t
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  entry_t                   wr_entry,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output entry_t                   rd_entry
);

  entry_t mem [DEPTH];

  // Store the incoming entry at the write pointer; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/spi_wr_buffer.sv
// First-word-fall-through buffer for decoded SPI write pulses. Holds pointers,
// the level counter (sole source of full/empty), overflow tracking and the
// zero-masking of the head outputs while empty.
module spi_wr_buffer
  import wr_buf_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic              spi_sck_in,
  input logic              reset_in_neg,
  spi_wr_buffer_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = level_width(DEPTH);
  localparam logic [LVL_W-1:0]      FULL_LVL = LVL_W'(DEPTH);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0]      level_reg, level_next;
  logic                  overflow_reg, overflow_next;
  logic [DROP_CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  logic   full, empty, pop, push, drop;
  entry_t wr_entry, head_entry;

  assign full  = (level_reg == FULL_LVL);
  assign empty = (level_reg == '0);

  // Pop depends only on registered state plus ready, so valid never depends on ready.
  // A pop frees a slot in the same cycle, so a write at full with a pop is accepted.
  assign pop  = !empty && bus.rd_ready_in;
  assign push = bus.wr_en_in && (!full || pop);
  assign drop = bus.wr_en_in && full && !pop;

  // Next-state for pointers, level, sticky overflow and saturating drop counter.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;
    overflow_next = overflow_reg;
    drop_cnt_next = drop_cnt_reg;

    if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);

    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      overflow_next = 1'b1;
    end else if (bus.clear_ovf_in) begin
      overflow_next = 1'b0;
    end

    if (drop && (drop_cnt_reg != DROP_MAX)) begin
      drop_cnt_next = drop_cnt_reg + DROP_CNT_W'(1);
    end
  end

  // State register; reset empties the buffer immediately.
  always_ff @(posedge spi_sck_in or negedge reset_in_neg) begin
    if (!reset_in_neg) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign wr_entry.addr = bus.wr_address_in;
  assign wr_entry.data = bus.wr_data_in;

  wr_buf_mem #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_mem (
    .clk      (spi_sck_in),
    .wr_en    (push),
    .wr_addr  (wr_ptr_reg),
    .wr_entry (wr_entry),
    .rd_addr  (rd_ptr_reg),
    .rd_entry (head_entry)
  );

  // Head outputs read as zero while empty so stale storage never leaks out.
  assign bus.rd_valid_out   = !empty;
  assign bus.rd_address_out = empty ? '0 : head_entry.addr;
  assign bus.rd_data_out    = empty ? '0 : head_entry.data;
  assign bus.level_out      = level_reg;
  assign bus.full_out       = full;
  assign bus.empty_out      = empty;
  assign bus.overflow_out   = overflow_reg;
  assign bus.drop_count_out = drop_cnt_reg;

endmodule

// File: tb/tb_spi_wr_buffer.sv
// Scoreboard bench for spi_wr_buffer: stimulus queues expected pops, a
// negedge monitor compares every accepted head against the queue.
module tb_spi_wr_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  spi_wr_buffer_if #(.DEPTH(8), .ADDR_W(24), .DATA_W(32)) bus ();

  spi_wr_buffer #(.DEPTH(8), .ADDR_W(24), .DATA_W(32)) dut (
    .spi_sck_in   (clk),
    .reset_in_neg (rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [55:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One-cycle write strobe; acc says whether the buffer should keep it.
  task automatic write_word(input logic [23:0] a, input logic [31:0] d, input bit acc);
    bus.wr_en_in      = 1'b1;
    bus.wr_address_in = a;
    bus.wr_data_in    = d;
    if (acc) exp_q.push_back({a, d});
    cycle();
    bus.wr_en_in = 1'b0;
  endtask

  // Monitor: every accepted head must match the oldest expected entry;
  // an idle head must read as zero.
  initial begin
    logic [55:0] e;
    forever begin
      @(negedge clk);
      if (bus.rd_valid_out && bus.rd_ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected got addr 0x%0h expected no entry", bus.rd_address_out);
        end else begin
          e = exp_q.pop_front();
          check("pop_addr", 64'(bus.rd_address_out), 64'(e[55:32]));
          check("pop_data", 64'(bus.rd_data_out), 64'(e[31:0]));
        end
      end else if (!bus.rd_valid_out) begin
        check("idle_head_mask", 64'({bus.rd_address_out, bus.rd_data_out}), 64'd0);
      end
    end
  end

  initial begin
    bus.wr_en_in      = 1'b0;
    bus.wr_address_in = '0;
    bus.wr_data_in    = '0;
    bus.rd_ready_in   = 1'b0;
    bus.clear_ovf_in  = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) cycle();
    check("rst_valid", 64'(bus.rd_valid_out), 64'd0);
    check("rst_level", 64'(bus.level_out), 64'd0);
    check("rst_empty", 64'(bus.empty_out), 64'd1);
    check("rst_full", 64'(bus.full_out), 64'd0);
    check("rst_ovf", 64'(bus.overflow_out), 64'd0);
    check("rst_drop", 64'(bus.drop_count_out), 64'd0);
    rst_n = 1'b1;
    cycle();

    // Single write: fall-through head after one edge, then pop
    write_word(24'h00FF00, 32'hFF00FF00, 1'b1);
    check("t1_valid", 64'(bus.rd_valid_out), 64'd1);
    check("t1_head_addr", 64'(bus.rd_address_out), 64'h00FF00);
    check("t1_head_data", 64'(bus.rd_data_out), 64'hFF00FF00);
    check("t1_level", 64'(bus.level_out), 64'd1);
    bus.rd_ready_in = 1'b1;
    cycle();
    bus.rd_ready_in = 1'b0;
    check("t1_empty", 64'(bus.empty_out), 64'd1);
    check("t1_masked", 64'({bus.rd_address_out, bus.rd_data_out}), 64'd0);

    // Fill to 8, 9th write dropped
    for (int i = 0; i < 8; i++) write_word(24'(i), 32'(i) * 32'h01010101, 1'b1);
    write_word(24'hABCDEF, 32'hDEADBEEF, 1'b0);
    check("t2_level", 64'(bus.level_out), 64'd8);
    check("t2_full", 64'(bus.full_out), 64'd1);
    check("t2_ovf", 64'(bus.overflow_out), 64'd1);
    check("t2_drop", 64'(bus.drop_count_out), 64'd1);

    // Write + pop at full: accepted, level stays 8
    bus.rd_ready_in = 1'b1;
    write_word(24'h123456, 32'h5A5A5A5A, 1'b1);
    bus.rd_ready_in = 1'b0;
    check("t3_level", 64'(bus.level_out), 64'd8);
    check("t3_drop", 64'(bus.drop_count_out), 64'd1);
    bus.rd_ready_in = 1'b1;
    repeat (8) cycle();
    bus.rd_ready_in = 1'b0;
    check("t3_empty", 64'(bus.empty_out), 64'd1);
    check("t3_queue_drained", 64'(exp_q.size()), 64'd0);

    // Saturating drop counter and overflow clear priority
    for (int i = 0; i < 8; i++) write_word(24'h200000 + 24'(i), 32'hA0000000 + 32'(i), 1'b1);
    bus.wr_en_in      = 1'b1;
    bus.wr_address_in = 24'hEEEEEE;
    repeat (300) cycle();
    check("t4_drop_sat", 64'(bus.drop_count_out), 64'd255);
    check("t4_level", 64'(bus.level_out), 64'd8);
    bus.clear_ovf_in = 1'b1;
    cycle();
    check("t4_drop_beats_clear", 64'(bus.overflow_out), 64'd1);
    bus.wr_en_in = 1'b0;
    cycle();
    bus.clear_ovf_in = 1'b0;
    check("t4_clear_ovf", 64'(bus.overflow_out), 64'd0);
    check("t4_drop_kept", 64'(bus.drop_count_out), 64'd255);
    bus.rd_ready_in = 1'b1;
    repeat (8) cycle();
    bus.rd_ready_in = 1'b0;
    check("t4_queue_drained", 64'(exp_q.size()), 64'd0);

    // Streaming with ready held high, across pointer wrap
    bus.rd_ready_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      write_word(24'h100000 + 24'(i), 32'hC0DE0000 + 32'(i), 1'b1);
      check("t5_stream_level", 64'(bus.level_out), 64'd1);
    end
    cycle();
    bus.rd_ready_in = 1'b0;
    check("t5_level_end", 64'(bus.level_out), 64'd0);
    check("t5_queue_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-stream with 5 entries held
    for (int i = 0; i < 5; i++) write_word(24'h300000 + 24'(i), 32'hB0000000 + 32'(i), 1'b1);
    check("t6_level5", 64'(bus.level_out), 64'd5);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_async_valid", 64'(bus.rd_valid_out), 64'd0);
    check("t6_async_level", 64'(bus.level_out), 64'd0);
    check("t6_async_empty", 64'(bus.empty_out), 64'd1);
    check("t6_async_head", 64'({bus.rd_address_out, bus.rd_data_out}), 64'd0);
    check("t6_async_ovf_drop", 64'({bus.overflow_out, bus.drop_count_out}), 64'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    write_word(24'h777777, 32'h13579BDF, 1'b1);
    check("t6_new_head", 64'(bus.rd_address_out), 64'h777777);
    bus.rd_ready_in = 1'b1;
    cycle();
    bus.rd_ready_in = 1'b0;
    check("t6_queue_drained", 64'(exp_q.size()), 64'd0);
    check("t6_empty_end", 64'(bus.empty_out), 64'd1);

    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
